pv2long_run_monitor: RTL

PV2LONG_RUN_MONITOR -- requirements
Module: pv2long_run_monitor

---
 rtl/pv2long_mon_pkg.sv | 21 ++
 rtl/pv2long_core_tracker.sv | 47 ++++
 rtl/pv2long_run_monitor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pv2long_mon_pkg.sv
// Shared types and constants for the long-run monitor: FSM encoding,
// pass status value and core-count limits.
package pv2long_mon_pkg;

  typedef enum logic [1:0] {
    RST_MEM  = 2'd0,
    RST_PROC = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } mon_state_e;

  localparam int          STATUS_W    = 32;
  localparam int          MAX_CORES   = 8;
  localparam int          IDX_W       = $clog2(MAX_CORES);
  localparam logic [31:0] PASS_STATUS = 32'd1;

  // Reset-sequencing delays are limited to 1..15 cycles.
  localparam int DLY_W = 4;
  typedef logic [DLY_W-1:0] dly_t;

endpackage

// File: rtl/pv2long_core_tracker.sv
// Per-core tracker: saturating retired-instruction counter plus a one-shot
// latch of the first nonzero status seen while the run is active.
module pv2long_core_tracker
  import pv2long_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                stats_en,
  input  logic                inst_val,
  input  logic [STATUS_W-1:0] status_in,
  output logic                finished,
  output logic [STATUS_W-1:0] status,
  output logic [CNT_W-1:0]    inst_cnt
);

  logic                fin_q;
  logic [STATUS_W-1:0] stat_q;
  logic                hit;

  assign hit = run && !fin_q && (status_in != '0);

  // NOTE: synchronous active-low reset; all state updates are non-blocking so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fin_q    <= 1'b0;
      stat_q   <= '0;
      inst_cnt <= '0;
    end else begin
      if (hit) begin
        fin_q  <= 1'b1;
        stat_q <= status_in;
      end
      if (run && stats_en && inst_val && (inst_cnt != '1))
        inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

  // Look-ahead view includes a status arriving this cycle, so the top can
  // register its verdict on the same edge that latches it here.
  assign finished = fin_q | hit;
  assign status   = fin_q ? stat_q : status_in;

endmodule

// File: rtl/pv2long_run_monitor.sv
// Long-run test monitor: sequences memory/core resets, then watches per-core
// CP0 status until all finish, one fails, or the cycle limit expires.
module pv2long_run_monitor
  import pv2long_mon_pkg::*;
#(
  parameter int NUM_CORES    = 2,
  parameter int CNT_W        = 32,
  parameter int MEM_RST_DLY  = 1,
  parameter int PROC_RST_DLY = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        max_cycles,
  input  logic                    stats_en,
  input  logic [32*NUM_CORES-1:0] core_status,
  input  logic [NUM_CORES-1:0]    core_inst_val,
  input  logic [2:0]              stat_sel,
  output logic                    mem_reset_o,
  output logic                    proc_reset_o,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [2:0]              fail_core,
  output logic [31:0]             fail_status,
  output logic [CNT_W-1:0]        stat_cycles,
  output logic [CNT_W-1:0]        stat_insts
);

  mon_state_e          state;
  dly_t                dly_cnt;
  logic                run;
  logic [NUM_CORES-1:0] fin_eff, pass_eff, fail_eff;
  logic [STATUS_W-1:0] status_eff [NUM_CORES];
  logic [CNT_W-1:0]    inst_cnt   [NUM_CORES];
  logic [IDX_W-1:0]    fail_idx;
  logic [STATUS_W-1:0] fail_stat;
  logic [CNT_W-1:0]    cyc_next;
  logic                any_fail, all_fin, timeout_hit, end_run;

  assign run = (state == RUN);

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    pv2long_core_tracker #(.CNT_W(CNT_W)) u_trk (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .stats_en (stats_en),
      .inst_val (core_inst_val[k]),
      .status_in(core_status[32*k +: 32]),
      .finished (fin_eff[k]),
      .status   (status_eff[k]),
      .inst_cnt (inst_cnt[k])
    );
    assign pass_eff[k] = fin_eff[k] && (status_eff[k] == PASS_STATUS);
    assign fail_eff[k] = fin_eff[k] && (status_eff[k] != PASS_STATUS);
  end

  // Descending scan so the lowest failing index wins.
  always_comb begin
    fail_idx  = '0;
    fail_stat = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (fail_eff[k]) begin
        fail_idx  = IDX_W'(k);
        fail_stat = status_eff[k];
      end
    end
  end

  always_comb begin
    stat_insts = '0;
    for (int k = 0; k < NUM_CORES; k++)
      if (stat_sel == 3'(k)) stat_insts = inst_cnt[k];
  end

  assign cyc_next    = (stat_cycles == '1) ? stat_cycles : stat_cycles + CNT_W'(1);
  assign any_fail    = |fail_eff;
  assign all_fin     = &fin_eff;
  assign timeout_hit = (max_cycles != '0) && (cyc_next == max_cycles);
  assign end_run     = all_fin || ((STOP_ON_FAIL != 0) && any_fail) || timeout_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RST_MEM;
      dly_cnt      <= '0;
      mem_reset_o  <= 1'b1;
      proc_reset_o <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_core    <= '0;
      fail_status  <= '0;
      stat_cycles  <= '0;
    end else begin
      case (state)
        RST_MEM: begin
          if (dly_cnt == dly_t'(MEM_RST_DLY - 1)) begin
            mem_reset_o <= 1'b0;
            dly_cnt     <= '0;
            state       <= RST_PROC;
          end else begin
            dly_cnt <= dly_cnt + dly_t'(1);
          end
        end
        RST_PROC: begin
          if (dly_cnt == dly_t'(PROC_RST_DLY - 1)) begin
            proc_reset_o <= 1'b0;
            dly_cnt      <= '0;
            state        <= RUN;
          end else begin
            dly_cnt <= dly_cnt + dly_t'(1);
          end
        end
        RUN: begin
          stat_cycles <= cyc_next;
          if (end_run) begin
            state       <= DONE;
            done        <= 1'b1;
            pass        <= &pass_eff;
            fail        <= any_fail;
            // A failure outranks the limit; a run that completes on the
            // limit edge is not a timeout either.
            timeout     <= timeout_hit && !all_fin && !any_fail;
            fail_core   <= fail_idx;
            fail_status <= fail_stat;
          end
        end
        DONE:    ;
        default: state <= RST_MEM;
      endcase
    end
  end

endmodule
